thunderbird_cmd_gen: RTL and testbench
======================================

Name: thunderbird_cmd_gen

Overview:
- Front-end initiator for the thunderbird tail-light sequencer. Conditions three raw dashboard switches (left, right, hazard) and emits the single-cycle command pulses that the sequencer consumes on its left/right/haz inputs.
- Per channel: 2-flop synchronizer, then debounce, then rising-edge detect.
- Then priority arbitration, then hold-off lock covering one full left/right animation.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
- HOLDOFF_CYCLES, 75000000: lock time after a left/right command (3 steps x 25M cycles).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sw_left  in  1  raw left switch, asynchronous, bouncy.
- i_sw_right  in  1  raw right switch, asynchronous, bouncy.
- i_sw_haz  in  1  raw hazard switch, asynchronous, bouncy.
- o_left  out  1  one-cycle left command pulse.
- o_right  out  1  one-cycle right command pulse.
- o_haz  out  1  one-cycle hazard command pulse.
- o_busy  out  1  high while in LOCK.

Interface decision: one clock (i_clk); reset i_rst_n is asynchronous and active-low.

Behaviour:
- Reset (i_rst_n=0, async):
  - all sync flops, stable levels and counters = 0.
  - state = IDLE; o_left = o_right = o_haz = o_busy = 0.
  - Mid-operation reset aborts LOCK immediately; no pulse is emitted during or on release of reset.
- Synchronizer: 2 flops per channel. s2 is the synchronized level.
- Debounce (per channel):
  - stable level register plus counter, width $clog2(DEBOUNCE_CYCLES+1).
  - s2 == stable: counter clears.
  - s2 != stable: counter increments. When counter reaches DEBOUNCE_CYCLES-1, stable <= s2 and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Edge detect: rise = stable & ~stable_d1. Falling edges generate nothing.
- Latency: raw rise sampled at edge 0 -> command pulse high in cycle after edge 2+DEBOUNCE_CYCLES+1. All outputs are registered.
- Arbitration (same cycle):
  - haz rise beats everything.
  - left rise and right rise together -> o_haz.
  - otherwise left or right alone.
  - At most one output pulse per cycle.
- FSM states IDLE, LOCK:
  - IDLE, haz cmd: o_haz pulse; stay IDLE.
  - IDLE, left/right cmd: matching pulse; go to LOCK; holdoff counter = 0; remember direction.
  - LOCK, o_busy=1, counter increments each cycle:
    - left/right rises are dropped, not queued.
    - haz cmd: o_haz pulse; go to IDLE; counter clears.
    - counter == HOLDOFF_CYCLES-1 -> IDLE (o_busy low next cycle).
- Holdoff counter width: $clog2(HOLDOFF_CYCLES+1), no wrap. It is only active in LOCK and cleared on entry.
- A switch held high through LOCK expiry does not re-fire (edge-only) unless the optional feature is enabled.

Optional Feature:
- Macro: THUNDERBIRD_AUTO_REPEAT_EN.
- Defined: at LOCK expiry, if the remembered direction's stable level is 1 and haz stable is 0, re-issue the same pulse in the expiry cycle, restart the counter, and stay in LOCK. The sequencer keeps blinking while the lever is held.
- Undefined: expiry always returns to IDLE with no pulse.

Decomposition:
- Shared package thunderbird_pkg:
  - FSM state enum (IDLE, LOCK).
  - direction enum (DIR_LEFT, DIR_RIGHT).
  - default cycle constants (25M step, 3 steps, 1M debounce).
- Sub-module sw_debounce (synchronizer + debounce + rise pulse), parameter DEBOUNCE_CYCLES. Instantiated 3x.

Test Plan (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=20):
- Left: raise i_sw_left at edge 0 and hold -> o_left=1 in exactly one cycle, 7 cycles later; o_busy high 20 cycles; no other pulses.
- Bounce: toggle i_sw_right with pulses of 3 cycles x5, then hold high -> a single o_right, 7 cycles after final rise; zero pulses during the bounce.
- Simultaneous: raise left and right on the same edge -> single o_haz; no o_left/o_right; o_busy stays 0.
- Drop and abort: left accepted, then right rise inside LOCK -> no o_right. Haz rise inside LOCK -> o_haz pulse, o_busy falls the next cycle.
- Reset: assert i_rst_n=0 asynchronously mid-LOCK -> o_busy=0 and all outputs 0 immediately. Release with switches low -> no pulses.
- Macro: with THUNDERBIRD_AUTO_REPEAT_EN, hold left for 70 cycles -> o_left pulses repeat every 20 cycles while held. Without the macro -> exactly one pulse.

Source files
------------

// File: rtl/thunderbird_pkg.sv
// Shared types and default timing constants for the thunderbird command front-end.
package thunderbird_pkg;

    // One animation step of the tail-light sequencer, in system clock cycles.
    localparam int unsigned STEP_CYCLES             = 25_000_000;
    localparam int unsigned LOCK_STEPS              = 3;
    localparam int unsigned DEFAULT_HOLDOFF_CYCLES  = STEP_CYCLES * LOCK_STEPS;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    typedef enum logic {
        IDLE,
        LOCK
    } state_e;

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchronizer, counter debounce and registered rise pulse.
module sw_debounce
    import thunderbird_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_d1_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the raw asynchronous switch into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= i_sw;
            s2_q <= s1_q;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state plus registered rising-edge pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stable_q    <= 1'b0;
            cnt_q       <= '0;
            stable_d1_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            stable_d1_q <= stable_q;
            rise_q      <= stable_q & ~stable_d1_q;
        end
    end

    assign o_level = stable_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/thunderbird_cmd_gen.sv
// Command front-end for the thunderbird tail-light sequencer: conditions the three
// dashboard switches, arbitrates their rising edges and holds off further left/right
// commands for one full animation.
// Optional feature macro THUNDERBIRD_AUTO_REPEAT_EN: re-fire a held left/right lever at
// every lock expiry instead of returning to IDLE.
module thunderbird_cmd_gen
    import thunderbird_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES  = DEFAULT_HOLDOFF_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw_left,
    input  logic i_sw_right,
    input  logic i_sw_haz,
    output logic o_left,
    output logic o_right,
    output logic o_haz,
    output logic o_busy
);

    localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    logic lvl_left;
    logic lvl_right;
    logic lvl_haz;
    logic rise_left;
    logic rise_right;
    logic rise_haz;

    logic cmd_haz;
    logic cmd_left;
    logic cmd_right;
    logic expire;

    state_e            state_q;
    state_e            state_d;
    dir_e              dir_q;
    dir_e              dir_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              left_q;
    logic              left_d;
    logic              right_q;
    logic              right_d;
    logic              haz_q;
    logic              haz_d;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_left (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_sw   (i_sw_left),
        .o_level(lvl_left),
        .o_rise (rise_left)
    );

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_right (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_sw   (i_sw_right),
        .o_level(lvl_right),
        .o_rise (rise_right)
    );

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_haz (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_sw   (i_sw_haz),
        .o_level(lvl_haz),
        .o_rise (rise_haz)
    );

    // Simultaneous left and right is treated as a hazard request.
    assign cmd_haz   = rise_haz | (rise_left & rise_right);
    assign cmd_left  = rise_left & ~cmd_haz;
    assign cmd_right = rise_right & ~cmd_haz;
    assign expire    = (hold_q == HOLD_W'(HOLDOFF_CYCLES - 1));

`ifdef THUNDERBIRD_AUTO_REPEAT_EN
    logic repeat_ok;
    assign repeat_ok = ((dir_q == DIR_LEFT) ? lvl_left : lvl_right) & ~lvl_haz;
`else
    logic unused_levels;
    assign unused_levels = lvl_left ^ lvl_right ^ lvl_haz ^ (dir_q == DIR_RIGHT);
`endif

    // Next-state and command pulse selection.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        hold_d  = hold_q;
        left_d  = 1'b0;
        right_d = 1'b0;
        haz_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (cmd_haz) begin
                    haz_d = 1'b1;
                end else if (cmd_left) begin
                    left_d  = 1'b1;
                    state_d = LOCK;
                    dir_d   = DIR_LEFT;
                end else if (cmd_right) begin
                    right_d = 1'b1;
                    state_d = LOCK;
                    dir_d   = DIR_RIGHT;
                end
            end
            LOCK: begin
                // Left/right rises are dropped here; only hazard can break the lock.
                if (cmd_haz) begin
                    haz_d   = 1'b1;
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (expire) begin
                    hold_d = '0;
`ifdef THUNDERBIRD_AUTO_REPEAT_EN
                    if (repeat_ok) begin
                        left_d  = (dir_q == DIR_LEFT);
                        right_d = (dir_q == DIR_RIGHT);
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // State, holdoff counter and registered command outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_LEFT;
            hold_q  <= '0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            haz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            left_q  <= left_d;
            right_q <= right_d;
            haz_q   <= haz_d;
        end
    end

    assign o_left  = left_q;
    assign o_right = right_q;
    assign o_haz   = haz_q;
    assign o_busy  = (state_q == LOCK);

endmodule

// File: tb/tb_thunderbird_cmd_gen.sv
// Scoreboard bench for thunderbird_cmd_gen with small debounce/holdoff constants.
module tb_thunderbird_cmd_gen;

    localparam int D = 4;
    localparam int H = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic sw_l  = 1'b0;
    logic sw_r  = 1'b0;
    logic sw_h  = 1'b0;
    logic o_left;
    logic o_right;
    logic o_haz;
    logic o_busy;

    int tests = 0;
    int fails = 0;

    thunderbird_cmd_gen #(
        .DEBOUNCE_CYCLES(D),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_sw_left (sw_l),
        .i_sw_right(sw_r),
        .i_sw_haz  (sw_h),
        .o_left    (o_left),
        .o_right   (o_right),
        .o_haz     (o_haz),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    // Expected pulses: edge index at which the output register is set, kind 0/1/2.
    typedef struct packed {
        int edge_id;
        int kind;
    } exp_t;
    exp_t  exp_q[$];
    string kname[3] = '{"left", "right", "haz"};

    // Reference model state (channel 0 left, 1 right, 2 haz).
    bit m1[3];
    bit m2[3];
    bit stb[3];
    bit hist[3][D];
    bit rq1[3];
    bit rq2[3];
    bit lock_active;
    int lock_end;
    int ldir;
    int edge_cnt  = 0;
    int last_edge = 0;
    bit step_done = 1'b0;

    task automatic push_exp(input int e, input int k);
        exp_t it;
        it.edge_id = e;
        it.kind    = k;
        exp_q.push_back(it);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m1[c]  = 1'b0;
            m2[c]  = 1'b0;
            stb[c] = 1'b0;
            rq1[c] = 1'b0;
            rq2[c] = 1'b0;
            for (int i = 0; i < D; i++) hist[c][i] = 1'b0;
        end
        lock_active = 1'b0;
        lock_end    = 0;
        ldir        = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit raw[3];
        bit newrise[3];
        bit ch;
        bit cl;
        bit cr;
        bit same;
        bit x;
        int k;
        k      = edge_cnt;
        raw[0] = sw_l;
        raw[1] = sw_r;
        raw[2] = sw_h;
        // Command decision uses rises debounced two edges earlier and current levels.
        ch = rq2[2] | (rq2[0] & rq2[1]);
        cl = rq2[0] & !ch;
        cr = rq2[1] & !ch;
        if (ch) begin
            push_exp(k, 2);
            lock_active = 1'b0;
        end else if (!lock_active) begin
            if (cl || cr) begin
                ldir = cl ? 0 : 1;
                push_exp(k, ldir);
                lock_active = 1'b1;
                lock_end    = k + H;
            end
        end else if (k == lock_end) begin
`ifdef THUNDERBIRD_AUTO_REPEAT_EN
            if (stb[ldir] && !stb[2]) begin
                push_exp(k, ldir);
                lock_end = k + H;
            end else begin
                lock_active = 1'b0;
            end
`else
            lock_active = 1'b0;
`endif
        end
        // Level accepted once the last D synchronized samples all agree on a new value.
        for (int c = 0; c < 3; c++) begin
            x     = m2[c];
            m2[c] = m1[c];
            m1[c] = raw[c];
            for (int i = 0; i < D - 1; i++) hist[c][i] = hist[c][i+1];
            hist[c][D-1] = x;
            same = 1'b1;
            for (int i = 0; i < D; i++) if (hist[c][i] != x) same = 1'b0;
            newrise[c] = 1'b0;
            if (same && x != stb[c]) begin
                stb[c]     = x;
                newrise[c] = x;
            end
            rq2[c] = rq1[c];
            rq1[c] = newrise[c];
        end
        last_edge = k;
        edge_cnt  = edge_cnt + 1;
        step_done = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else if (clk) model_step();
        end
    end

    // Monitor: compare DUT pulses and busy against the model, 1 time unit after each edge.
    initial begin
        int np;
        int kind;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && step_done) begin
                step_done = 1'b0;
                while (exp_q.size() > 0 && exp_q[0].edge_id < last_edge) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_pulse edge=%0d got none required %s",
                             exp_q[0].edge_id, kname[exp_q[0].kind]);
                    void'(exp_q.pop_front());
                end
                np = int'(o_left) + int'(o_right) + int'(o_haz);
                if (np > 1) begin
                    tests++;
                    fails++;
                    $display("FAIL multi_pulse edge=%0d got l=%b r=%b h=%b required at most one",
                             last_edge, o_left, o_right, o_haz);
                    if (exp_q.size() > 0 && exp_q[0].edge_id == last_edge)
                        void'(exp_q.pop_front());
                end else if (np == 1) begin
                    kind = o_left ? 0 : (o_right ? 1 : 2);
                    tests++;
                    if (exp_q.size() > 0 && exp_q[0].edge_id == last_edge) begin
                        if (exp_q[0].kind != kind) begin
                            fails++;
                            $display("FAIL pulse_kind edge=%0d got %s required %s",
                                     last_edge, kname[kind], kname[exp_q[0].kind]);
                        end
                        void'(exp_q.pop_front());
                    end else begin
                        fails++;
                        $display("FAIL unexpected_pulse edge=%0d got %s required none",
                                 last_edge, kname[kind]);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].edge_id == last_edge) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_pulse edge=%0d got none required %s",
                             last_edge, kname[exp_q[0].kind]);
                    void'(exp_q.pop_front());
                end
                tests++;
                if (o_busy !== lock_active) begin
                    fails++;
                    $display("FAIL busy edge=%0d got %b required %b",
                             last_edge, o_busy, lock_active);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        tests++;
        if ({o_left, o_right, o_haz, o_busy} !== 4'b0000) begin
            fails++;
            $display("FAIL %s got l=%b r=%b h=%b busy=%b required all 0",
                     name, o_left, o_right, o_haz, o_busy);
        end
    endtask

    initial begin
        int dur[3];
        bit lvl[3];
        rst_n = 1'b0;
        cycles(3);
        check_quiet("reset_state");
        rst_n = 1'b1;
        cycles(3);

        // Single left command.
        sw_l = 1'b1;
        cycles(30);
        sw_l = 1'b0;
        cycles(15);

        // Bouncy right lever, then a clean hold.
        repeat (5) begin
            sw_r = 1'b1;
            cycles(3);
            sw_r = 1'b0;
            cycles(3);
        end
        sw_r = 1'b1;
        cycles(30);
        sw_r = 1'b0;
        cycles(15);

        // Left and right together.
        sw_l = 1'b1;
        sw_r = 1'b1;
        cycles(15);
        sw_l = 1'b0;
        sw_r = 1'b0;
        cycles(10);

        // Right dropped inside lock, hazard aborts lock.
        sw_l = 1'b1;
        cycles(10);
        sw_r = 1'b1;
        cycles(3);
        sw_h = 1'b1;
        cycles(10);
        sw_l = 1'b0;
        sw_r = 1'b0;
        sw_h = 1'b0;
        cycles(15);

        // Asynchronous reset in the middle of lock.
        sw_l = 1'b1;
        cycles(10);
        rst_n = 1'b0;
        sw_l  = 1'b0;
        #1;
        check_quiet("reset_mid_lock");
        cycles(3);
        rst_n = 1'b1;
        cycles(20);

        // Long hold: one pulse, or periodic pulses with auto-repeat.
        sw_l = 1'b1;
        cycles(70);
        sw_l = 1'b0;
        cycles(40);

        // Random lever activity with occasional resets.
        for (int c = 0; c < 3; c++) begin
            dur[c] = $urandom_range(1, 30);
            lvl[c] = 1'b0;
        end
        repeat (2000) begin
            for (int c = 0; c < 3; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    lvl[c] = ~lvl[c];
                    dur[c] = (c == 2 && lvl[c]) ? int'($urandom_range(1, 8))
                                                : int'($urandom_range(1, 40));
                end
            end
            sw_l = lvl[0];
            sw_r = lvl[1];
            sw_h = lvl[2];
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                cycles(2);
                rst_n = 1'b1;
            end
            cycles(1);
        end
        sw_l = 1'b0;
        sw_r = 1'b0;
        sw_h = 1'b0;
        cycles(60);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_pulses got %0d outstanding required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
